// File: rtl/decode_stage_pipe.sv
// Decode stage for the RV32I/RV32E pipeline: register file, full decode, ID/EX register, load-use stall.
// Optional macro RF_WRITE_BYPASS_EN: same-cycle writeback data is forwarded to the read ports.
module decode_stage_pipe #(
    parameter int XLEN         = 32,
    parameter int NREGS        = 32,
    parameter bit RST_CLEAR_RF = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1_data,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic            out_funct7b5,
    output logic [8:0]      out_ctrl,
    output logic            out_illegal
);

    localparam int AW = $clog2(NREGS);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam int C_RW  = 8;
    localparam int C_MR  = 7;
    localparam int C_MW  = 6;
    localparam int C_AS  = 5;
    localparam int C_BR  = 4;
    localparam int C_MTR = 3;
    localparam int C_J   = 2;
    localparam int C_AU  = 1;
    localparam int C_LUI = 0;

    logic [XLEN-1:0] r_rf [NREGS];

    logic [6:0]         w_opcode;
    logic [4:0]         w_rs1, w_rs2, w_rd;
    logic               w_known, w_use1, w_use2, w_bad_reg, w_illegal;
    logic [8:0]         w_ctrl_raw, w_ctrl;
    logic signed [31:0] w_imm32;
    logic [XLEN-1:0]    w_imm;
    logic [XLEN-1:0]    w_rs1_data, w_rs2_data;
    logic               w_wr_en, w_hz, w_adv;

    logic            r_valid;
    logic [XLEN-1:0] r_pc, r_rs1_data, r_rs2_data, r_imm;
    logic [4:0]      r_rs1, r_rs2, r_rd;
    logic [2:0]      r_funct3;
    logic            r_funct7b5;
    logic [8:0]      r_ctrl;
    logic            r_illegal;

    assign w_opcode = in_instr[6:0];
    assign w_rd     = in_instr[11:7];
    assign w_rs1    = in_instr[19:15];
    assign w_rs2    = in_instr[24:20];

    always_comb begin
        w_known    = 1'b1;
        w_use1     = 1'b1;
        w_use2     = 1'b0;
        w_ctrl_raw = '0;
        w_imm32    = '0;
        case (w_opcode)
            OPC_LUI: begin
                w_use1 = 1'b0;
                w_ctrl_raw[C_RW]  = 1'b1;
                w_ctrl_raw[C_AS]  = 1'b1;
                w_ctrl_raw[C_LUI] = 1'b1;
                w_imm32 = {in_instr[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                w_use1 = 1'b0;
                w_ctrl_raw[C_RW] = 1'b1;
                w_ctrl_raw[C_AS] = 1'b1;
                w_ctrl_raw[C_AU] = 1'b1;
                w_imm32 = {in_instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                w_use1 = 1'b0;
                w_ctrl_raw[C_RW] = 1'b1;
                w_ctrl_raw[C_J]  = 1'b1;
                w_imm32 = 32'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
            end
            OPC_JALR: begin
                w_ctrl_raw[C_RW] = 1'b1;
                w_ctrl_raw[C_AS] = 1'b1;
                w_ctrl_raw[C_J]  = 1'b1;
                w_imm32 = 32'($signed(in_instr[31:20]));
            end
            OPC_BRANCH: begin
                w_use2 = 1'b1;
                w_ctrl_raw[C_BR] = 1'b1;
                w_imm32 = 32'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
            end
            OPC_LOAD: begin
                w_ctrl_raw[C_RW]  = 1'b1;
                w_ctrl_raw[C_MR]  = 1'b1;
                w_ctrl_raw[C_AS]  = 1'b1;
                w_ctrl_raw[C_MTR] = 1'b1;
                w_imm32 = 32'($signed(in_instr[31:20]));
            end
            OPC_STORE: begin
                w_use2 = 1'b1;
                w_ctrl_raw[C_MW] = 1'b1;
                w_ctrl_raw[C_AS] = 1'b1;
                w_imm32 = 32'($signed({in_instr[31:25], in_instr[11:7]}));
            end
            OPC_OPIMM: begin
                w_ctrl_raw[C_RW] = 1'b1;
                w_ctrl_raw[C_AS] = 1'b1;
                w_imm32 = 32'($signed(in_instr[31:20]));
            end
            OPC_OP: begin
                w_use2 = 1'b1;
                w_ctrl_raw[C_RW] = 1'b1;
            end
            default: w_known = 1'b0;
        endcase
    end

    // RV32E: an index above x15 in any field the opcode actually uses is illegal
    assign w_bad_reg = (NREGS < 32) &&
                       ((w_use1 && w_rs1[4]) || (w_use2 && w_rs2[4]) || (w_ctrl_raw[C_RW] && w_rd[4]));
    assign w_illegal = ~w_known | w_bad_reg;
    assign w_ctrl    = w_illegal ? '0 : {w_ctrl_raw[C_RW] & (w_rd != '0), w_ctrl_raw[7:0]};
    assign w_imm     = w_illegal ? '0 : XLEN'(w_imm32);

    assign w_wr_en = wb_we && (wb_rd != '0) && (32'(wb_rd) < NREGS);

    always_comb begin
        w_rs1_data = '0;
        if ((w_rs1 != '0) && (32'(w_rs1) < NREGS)) begin
            w_rs1_data = r_rf[w_rs1[AW-1:0]];
`ifdef RF_WRITE_BYPASS_EN
            if (w_wr_en && (wb_rd == w_rs1)) w_rs1_data = wb_data;
`endif
        end
    end

    always_comb begin
        w_rs2_data = '0;
        if ((w_rs2 != '0) && (32'(w_rs2) < NREGS)) begin
            w_rs2_data = r_rf[w_rs2[AW-1:0]];
`ifdef RF_WRITE_BYPASS_EN
            if (w_wr_en && (wb_rd == w_rs2)) w_rs2_data = wb_data;
`endif
        end
    end

    generate
        if (RST_CLEAR_RF) begin : g_rf_clear
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int unsigned i = 0; i < NREGS; i++) r_rf[i] <= '0;
                end else if (w_wr_en) begin
                    r_rf[wb_rd[AW-1:0]] <= wb_data;
                end
            end
        end else begin : g_rf_keep
            always_ff @(posedge clk) begin
                if (w_wr_en) r_rf[wb_rd[AW-1:0]] <= wb_data;
            end
        end
    endgenerate

    assign w_hz = in_valid & r_valid & r_ctrl[C_MR] & (r_rd != '0) &
                  ((w_use1 & (w_rs1 == r_rd)) | (w_use2 & (w_rs2 == r_rd)));
    assign w_adv    = ~r_valid | out_ready;
    assign in_ready = flush | (w_adv & ~w_hz);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_funct3   <= '0;
            r_funct7b5 <= 1'b0;
            r_ctrl     <= '0;
            r_illegal  <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_adv) begin
            if (w_hz || !in_valid) begin
                r_valid <= 1'b0;
            end else begin
                r_valid    <= 1'b1;
                r_pc       <= in_pc;
                r_rs1_data <= w_rs1_data;
                r_rs2_data <= w_rs2_data;
                r_imm      <= w_imm;
                r_rs1      <= w_rs1;
                r_rs2      <= w_rs2;
                r_rd       <= w_rd;
                r_funct3   <= in_instr[14:12];
                r_funct7b5 <= in_instr[30];
                r_ctrl     <= w_ctrl;
                r_illegal  <= w_illegal;
            end
        end
    end

    assign out_valid    = r_valid;
    assign out_pc       = r_pc;
    assign out_rs1_data = r_rs1_data;
    assign out_rs2_data = r_rs2_data;
    assign out_imm      = r_imm;
    assign out_rs1      = r_rs1;
    assign out_rs2      = r_rs2;
    assign out_rd       = r_rd;
    assign out_funct3   = r_funct3;
    assign out_funct7b5 = r_funct7b5;
    assign out_ctrl     = r_ctrl;
    assign out_illegal  = r_illegal;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe (default parameters) with an instruction-level reference model.
module tb_decode_stage_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [2:0]  out_funct3;
    logic        out_funct7b5;
    logic [8:0]  out_ctrl;
    logic        out_illegal;

    decode_stage_pipe #(.XLEN(32), .NREGS(32), .RST_CLEAR_RF(1'b1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_funct3(out_funct3), .out_funct7b5(out_funct7b5),
        .out_ctrl(out_ctrl), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference ID/EX contents and architectural registers
    logic        m_valid;
    logic [31:0] m_pc, m_r1d, m_r2d, m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [2:0]  m_f3;
    logic        m_f7;
    logic [8:0]  m_ctrl;
    logic        m_ill;
    logic [31:0] mrf [32];

    localparam logic [31:0] I_ADDI_M5  = 32'hFFB00093; // addi x1,x0,-5
    localparam logic [31:0] I_BAD      = 32'h0000007F;
    localparam logic [31:0] I_BEQ_M8   = 32'hFE208CE3; // beq x1,x2,-8
    localparam logic [31:0] I_SW       = 32'h00512623; // sw x5,12(x2)
    localparam logic [31:0] I_JAL16    = 32'h010000EF; // jal x1,16
    localparam logic [31:0] I_LUI      = 32'h00001237; // lui x4,1
    localparam logic [31:0] I_LW       = 32'h00012183; // lw x3,0(x2)
    localparam logic [31:0] I_ADD_USE  = 32'h00118233; // add x4,x3,x1
    localparam logic [31:0] I_ADD_X7   = 32'h00038433; // add x8,x7,x0
    localparam logic [31:0] I_ADD_X0   = 32'h000004B3; // add x9,x0,x0
    localparam logic [31:0] I_ADD_X5   = 32'h00028333; // add x6,x5,x0

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic void ref_decode(input logic [31:0] ins, output logic [8:0] ctrl,
                                       output logic [31:0] imm, output logic ill,
                                       output logic u1, output logic u2);
        logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
        i_imm = 32'($signed(ins[31:20]));
        s_imm = 32'($signed({ins[31:25], ins[11:7]}));
        b_imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        u_imm = {ins[31:12], 12'h000};
        j_imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        ill = 1'b0; u1 = 1'b1; u2 = 1'b0;
        case (ins[6:0])
            7'h37:   begin ctrl = 9'b100100001; imm = u_imm; u1 = 1'b0; end
            7'h17:   begin ctrl = 9'b100100010; imm = u_imm; u1 = 1'b0; end
            7'h6F:   begin ctrl = 9'b100000100; imm = j_imm; u1 = 1'b0; end
            7'h67:   begin ctrl = 9'b100100100; imm = i_imm; end
            7'h63:   begin ctrl = 9'b000010000; imm = b_imm; u2 = 1'b1; end
            7'h03:   begin ctrl = 9'b110101000; imm = i_imm; end
            7'h23:   begin ctrl = 9'b001100000; imm = s_imm; u2 = 1'b1; end
            7'h13:   begin ctrl = 9'b100100000; imm = i_imm; end
            7'h33:   begin ctrl = 9'b100000000; imm = 32'h0; u2 = 1'b1; end
            default: begin ctrl = 9'b000000000; imm = 32'h0; ill = 1'b1; end
        endcase
        if (ins[11:7] == 5'd0) ctrl[8] = 1'b0;
    endfunction

    function automatic logic [31:0] rf_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
`ifdef RF_WRITE_BYPASS_EN
        if (wb_we && wb_rd == idx) return wb_data;
`endif
        return mrf[idx];
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_pc = '0; m_r1d = '0; m_r2d = '0; m_imm = '0;
        m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_f3 = '0; m_f7 = 1'b0; m_ctrl = '0; m_ill = 1'b0;
        for (int i = 0; i < 32; i++) mrf[i] = '0;
    endtask

    // One clock: check in_ready, advance the model, then compare the registered outputs.
    task automatic step();
        logic [8:0]  c;
        logic [31:0] im, d1, d2;
        logic        il, u1, u2, hz, adv;
        #1;
        ref_decode(in_instr, c, im, il, u1, u2);
        hz  = in_valid && m_valid && m_ctrl[7] && (m_rd != 5'd0) &&
              ((u1 && in_instr[19:15] == m_rd) || (u2 && in_instr[24:20] == m_rd));
        adv = !m_valid || out_ready;
        chk("in_ready", {31'b0, in_ready}, {31'b0, flush || (adv && !hz)});
        d1 = rf_read(in_instr[19:15]);
        d2 = rf_read(in_instr[24:20]);
        @(posedge clk);
        if (flush) m_valid = 1'b0;
        else if (adv) begin
            if (hz || !in_valid) m_valid = 1'b0;
            else begin
                m_valid = 1'b1; m_pc = in_pc; m_r1d = d1; m_r2d = d2; m_imm = im;
                m_rs1 = in_instr[19:15]; m_rs2 = in_instr[24:20]; m_rd = in_instr[11:7];
                m_f3 = in_instr[14:12]; m_f7 = in_instr[30]; m_ctrl = c; m_ill = il;
            end
        end
        if (wb_we && wb_rd != 5'd0) mrf[wb_rd] = wb_data;
        #1;
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        if (m_valid) begin
            chk("out_pc", out_pc, m_pc);
            chk("out_rs1_data", out_rs1_data, m_r1d);
            chk("out_rs2_data", out_rs2_data, m_r2d);
            chk("out_imm", out_imm, m_imm);
            chk("out_regs", {17'b0, out_rs1, out_rs2, out_rd}, {17'b0, m_rs1, m_rs2, m_rd});
            chk("out_funct", {28'b0, out_funct3, out_funct7b5}, {28'b0, m_f3, m_f7});
            chk("out_ctrl", {23'b0, out_ctrl}, {23'b0, m_ctrl});
            chk("out_illegal", {31'b0, out_illegal}, {31'b0, m_ill});
        end
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] data);
        wb_we = 1'b1; wb_rd = rd; wb_data = data; in_valid = 1'b0;
        step();
        wb_we = 1'b0;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
        in_valid = 1'b1; in_instr = ins; in_pc = pc;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_imm", out_imm, 32'h0);
        chk("rst_ctrl", {23'b0, out_ctrl}, 32'h0);
        rst = 1'b0;

        wb(5'd1, 32'h11);
        wb(5'd2, 32'h100);
        wb(5'd5, 32'h1234);
        wb(5'd7, 32'h77);

        issue(I_ADDI_M5, 32'h100);
        chk("addi_imm", out_imm, 32'hFFFFFFFB);
        chk("addi_ctrl", {23'b0, out_ctrl}, 32'h120);
        chk("addi_rd", {27'b0, out_rd}, 32'd1);
        chk("addi_ill", {31'b0, out_illegal}, 32'h0);

        issue(I_BAD, 32'h104);
        chk("bad_ill", {31'b0, out_illegal}, 32'h1);
        chk("bad_ctrl", {23'b0, out_ctrl}, 32'h0);

        issue(I_BEQ_M8, 32'h108);
        chk("beq_imm", out_imm, 32'hFFFFFFF8);
        chk("beq_ops", out_rs2_data, 32'h100);
        issue(I_SW, 32'h10C);
        chk("sw_imm", out_imm, 32'hC);
        chk("sw_data", out_rs2_data, 32'h1234);
        issue(I_JAL16, 32'h110);
        chk("jal_imm", out_imm, 32'h10);
        chk("jal_ctrl", {23'b0, out_ctrl}, 32'h104);

        // load-use: stall one cycle, bubble, then issue
        in_valid = 1'b1; in_instr = I_LW; in_pc = 32'h200;
        step();
        in_instr = I_ADD_USE; in_pc = 32'h204;
        #1 chk("lu_stall", {31'b0, in_ready}, 32'h0);
        step();
        chk("lu_bubble", {31'b0, out_valid}, 32'h0);
        step();
        chk("lu_issue", {27'b0, out_rd}, 32'd4);

        in_instr = I_LW; in_pc = 32'h208;
        step();
        in_instr = I_LUI; in_pc = 32'h20C;
        #1 chk("lui_nostall", {31'b0, in_ready}, 32'h1);
        step();
        chk("lui_ctrl", {23'b0, out_ctrl}, 32'h121);
        chk("lui_imm", out_imm, 32'h1000);

        // backpressure holds the lui in ID/EX
        in_instr = I_ADDI_M5; in_pc = 32'h210; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold", out_pc, 32'h20C);
        end
        out_ready = 1'b1;
        step();
        chk("bp_release", out_pc, 32'h210);

        // flush overrides a pending hazard
        in_instr = I_LW; in_pc = 32'h220;
        step();
        in_instr = I_ADD_USE; in_pc = 32'h224; flush = 1'b1;
        #1 chk("fl_ready", {31'b0, in_ready}, 32'h1);
        step();
        chk("fl_drop", {31'b0, out_valid}, 32'h0);
        flush = 1'b0; in_valid = 1'b0;
        step();

        // same-cycle writeback versus read
        wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEAD;
        issue(I_ADD_X7, 32'h300);
        wb_we = 1'b0;
`ifdef RF_WRITE_BYPASS_EN
        chk("wb_same", out_rs1_data, 32'hDEAD);
`else
        chk("wb_same", out_rs1_data, 32'h77);
`endif
        issue(I_ADD_X7, 32'h304);
        chk("wb_after", out_rs1_data, 32'hDEAD);

        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hBEEF;
        issue(I_ADD_X0, 32'h308);
        wb_we = 1'b0;
        issue(I_ADD_X0, 32'h30C);
        chk("x0_zero", out_rs1_data, 32'h0);

        // asynchronous reset mid-stream
        issue(I_ADD_X5, 32'h400);
        chk("pre_rst_x5", out_rs1_data, 32'h1234);
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'b0, out_valid}, 32'h0);
        chk("arst_pc", out_pc, 32'h0);
        chk("arst_data", out_rs1_data, 32'h0);
        chk("arst_rd", {27'b0, out_rd}, 32'h0);
        model_reset();
        #1 rst = 1'b0;
        issue(I_ADD_X5, 32'h404);
        chk("post_rst_x5", out_rs1_data, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
